// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: opcodes, ALU codes,
// FSM states and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_RS1 = 2'd2;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_e;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction decoder: splits the IR into register indices,
// ALU op, write-back source and control flags.
module cpu_instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [2:0]  rd,
  output logic [2:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        is_write,
  output logic        is_branch,
  output logic        is_jmp,
  output logic        is_halt,
  output logic        illegal
);

  logic [3:0] op;

  always_comb begin
    op        = ir[OP_LSB +: 4];
    rd        = ir[RD_LSB +: 3];
    rs1       = ir[RS1_LSB +: 3];
    rs2       = ir[RS2_LSB +: 3];
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    is_write  = 1'b0;
    is_branch = 1'b0;
    is_jmp    = 1'b0;
    is_halt   = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        is_write = 1'b1;
        alu_op   = op[2:0] - 3'd1;
      end
      OP_LDI: begin
        is_write = 1'b1;
        wb_sel   = WB_IMM;
      end
      OP_MOV: begin
        is_write = 1'b1;
        wb_sel   = WB_RS1;
      end
      OP_JMP:  is_jmp = 1'b1;
      OP_BEQZ: begin
        // BEQZ tests the register in the rd slot
        is_branch = 1'b1;
        rs1       = ir[RD_LSB +: 3];
      end
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the register file,
// ALU op and instruction fetch; owns pc, ir and the write-back register.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [2:0]         rd,
  input  logic [7:0]         read_data1,
  input  logic [7:0]         read_data2,
  output logic [2:0]         alu_op,
  input  logic [7:0]         alu_result,
  output logic [7:0]         write_data,
  output logic               reg_write,
  output logic               halted,
  output logic               illegal
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [7:0]         wb_q, wb_d;
  logic               run_q, run_d;

  logic [2:0] dec_rs1, dec_rs2, dec_rd, dec_alu_op;
  logic [1:0] dec_wb_sel;
  logic       dec_is_write, dec_is_branch, dec_is_jmp, dec_is_halt, dec_illegal;
  logic [7:0] imm8;

  cpu_instr_decoder u_dec (
    .ir        (ir_q[15:0]),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .alu_op    (dec_alu_op),
    .wb_sel    (dec_wb_sel),
    .is_write  (dec_is_write),
    .is_branch (dec_is_branch),
    .is_jmp    (dec_is_jmp),
    .is_halt   (dec_is_halt),
    .illegal   (dec_illegal)
  );

  assign imm8      = ir_q[IMM_LSB +: 8];
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wb_d       = wb_q;
    run_d      = 1'b1;
    imem_req   = 1'b0;
    rs1        = 3'd0;
    rs2        = 3'd0;
    rd         = 3'd0;
    alu_op     = 3'd0;
    write_data = 8'd0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    // indices and ALU op stay put for the whole DECODE..WB window
    if (state_q inside {S_DECODE, S_EXEC, S_WB}) begin
      rs1    = dec_rs1;
      rs2    = dec_rs2;
      rd     = dec_rd;
      alu_op = dec_alu_op;
    end

    case (state_q)
      S_FETCH: begin
        // run_q holds off the first request until one cycle after reset release
        imem_req = run_q;
        if (run_q && imem_valid) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        illegal = dec_illegal;
        case (dec_wb_sel)
          WB_IMM:  wb_d = imm8;
          WB_RS1:  wb_d = read_data1;
          default: wb_d = alu_result;
        endcase
        if (dec_is_jmp || (dec_is_branch && read_data1 == 8'd0))
          pc_d = PC_W'(imm8);
        state_d = dec_is_halt ? S_HALTED : S_WB;
      end
      S_WB: begin
        reg_write  = dec_is_write;
        write_data = dec_is_write ? wb_q : 8'd0;
        state_d    = S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      wb_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wb_q    <= wb_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench: an instruction-level model runs each fetched instruction
// and queues the register writes / illegal pulses the sequencer must produce.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [2:0]  rs1, rs2, rd, alu_op;
  logic [7:0]  read_data1, read_data2, alu_result, write_data;
  logic        reg_write, halted, illegal;

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .rs1(rs1), .rs2(rs2),
    .rd(rd), .read_data1(read_data1), .read_data2(read_data2), .alu_op(alu_op),
    .alu_result(alu_result), .write_data(write_data), .reg_write(reg_write),
    .halted(halted), .illegal(illegal)
  );

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    logic [2:0] aop;
    bit         alu;
  } wexp_t;

  logic [15:0] prog [256];
  logic [7:0]  rf [8];
  logic [7:0]  rf_init [8];
  logic [7:0]  mrf [8];
  logic [7:0]  mpc;
  bit          m_halt;
  bit          rf_load;
  wexp_t       exp_q [$];
  int          exp_ill;
  int          fixed_wait;
  int          wait_max;
  int          total = 0;
  int          bad = 0;

  function automatic logic [7:0] aluf(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] r, input logic [7:0] imm);
    return {op, r, 1'b0, imm};
  endfunction

  // environment: register file and ALU around the sequencer
  assign read_data1 = rf[rs1];
  assign read_data2 = rf[rs2];
  assign alu_result = aluf(alu_op, read_data1, read_data2);

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (reg_write) begin
      rf[rd] <= write_data;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mexec(input logic [15:0] ins);
    logic [3:0] op;
    logic [2:0] d, a, b, aop;
    logic [7:0] imm, v;
    op  = ins[15:12];
    d   = ins[11:9];
    a   = ins[8:6];
    b   = ins[5:3];
    imm = ins[7:0];
    mpc = mpc + 8'd1;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        aop = op[2:0] - 3'd1;
        v = aluf(aop, mrf[a], mrf[b]);
        mrf[d] = v;
        exp_q.push_back('{d, v, aop, 1'b1});
      end
      4'h6: begin mrf[d] = imm; exp_q.push_back('{d, imm, 3'd0, 1'b0}); end
      4'h7: begin v = mrf[a]; mrf[d] = v; exp_q.push_back('{d, v, 3'd0, 1'b0}); end
      4'h8: mpc = imm;
      4'h9: if (mrf[d] == 8'd0) mpc = imm;
      4'hF: m_halt = 1'b1;
      4'h0: ;
      default: exp_ill++;
    endcase
  endtask

  // imem driver: wait states, spurious valids outside FETCH, model stepping
  initial begin
    int wcnt;
    wcnt = -1;
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (!rst_n) begin
        mpc = 8'd0;
        m_halt = 1'b0;
        exp_q.delete();
        exp_ill = 0;
        for (int i = 0; i < 8; i++) mrf[i] = rf_init[i];
        wcnt = -1;
      end
      if (imem_req) begin
        chk("fetch_after_halt", m_halt, 1'b0);
        chk("fetch_addr", imem_addr, mpc);
        if (wcnt < 0) wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
        if (wcnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = prog[imem_addr];
          mexec(prog[imem_addr]);
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        imem_valid = 1'b1;
        imem_rdata = 16'($urandom);
      end
    end
  end

  // monitor: pop expectations whenever the DUT writes or flags illegal
  initial begin
    wexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_write) begin
          chk("write_expected", 16'(exp_q.size() > 0), 16'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_rd", rd, e.rd);
            chk("wr_data", write_data, e.data);
            if (e.alu) chk("wr_alu_op", alu_op, e.aop);
          end
        end else begin
          chk("wdata_idle_zero", write_data, 8'd0);
        end
        if (illegal) begin
          chk("illegal_expected", 16'(exp_ill > 0), 16'd1);
          if (exp_ill > 0) exp_ill--;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    rf_load = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 8'd0);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_write_data", write_data, 8'd0);
    chk("rst_rd_aluop", {rd, alu_op}, 6'd0);
    rf_load = 1'b0;
    rst_n = 1'b1;
    #1 chk("req_low_at_release", imem_req, 1'b0);
    @(posedge clk);
    #1 chk("req_rise_after_release", imem_req, 1'b1);
  endtask

  task automatic run_prog(input string nm);
    int cyc;
    do_reset();
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_halt_reached"}, halted, 1'b1);
    chk({nm, "_model_halted"}, m_halt, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk({nm, "_halt_hold"}, {halted, imem_req, reg_write}, 3'b100);
    end
    chk({nm, "_writes_left"}, 16'(exp_q.size()), 16'd0);
    chk({nm, "_illegal_left"}, 16'(exp_ill), 16'd0);
    for (int i = 0; i < 8; i++) chk({nm, "_reg"}, rf[i], mrf[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
    for (int i = 0; i < 8; i++) rf_init[i] = 8'(8'h10 * i + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    rf_load = 1'b1;
    fixed_wait = -1;
    wait_max = 0;

    // reset asserted in the middle of WB: no write may land
    clear_prog();
    rf_init[2] = 8'h77;
    prog[0] = enc_i(4'h6, 3'd2, 8'h2A);
    fixed_wait = 0;
    do_reset();
    repeat (3) @(posedge clk);
    #1 chk("in_wb_before_reset", reg_write, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("midwb_reg_write", reg_write, 1'b0);
    chk("midwb_pc", imem_addr, 8'd0);
    @(posedge clk);
    #1 chk("midwb_no_write", rf[2], 8'h77);
    run_prog("ldi_after_reset");

    // LDI then ADD using it
    clear_prog();
    rf_init[0] = 8'd10;
    prog[0] = enc_i(4'h6, 3'd2, 8'h2A);
    prog[1] = enc_r(4'h1, 3'd3, 3'd0, 3'd2);
    run_prog("ldi_add");
    chk("ldi_add_r3", rf[3], 8'h34);

    // imem wait states, plus MOV / SUB / XOR
    fixed_wait = 3;
    prog[2] = enc_r(4'h7, 3'd5, 3'd3, 3'd0);
    prog[3] = enc_r(4'h2, 3'd6, 3'd5, 3'd0);
    prog[4] = enc_r(4'h5, 3'd7, 3'd6, 3'd2);
    run_prog("wait3");
    chk("wait3_r6", rf[6], 8'h2A);
    fixed_wait = 0;

    // BEQZ taken / not taken
    clear_prog();
    prog[0] = enc_i(4'h9, 3'd1, 8'h10);
    prog[1] = enc_i(4'h6, 3'd4, 8'h02);
    prog[16] = enc_i(4'h6, 3'd4, 8'h01);
    rf_init[1] = 8'd0;
    run_prog("beqz_taken");
    chk("beqz_taken_r4", rf[4], 8'h01);
    rf_init[1] = 8'd5;
    run_prog("beqz_not_taken");
    chk("beqz_nt_r4", rf[4], 8'h02);

    // pc wrap 0xFF -> 0x00, JMP
    clear_prog();
    rf_init[7] = 8'd0;
    prog[0]   = enc_i(4'h9, 3'd7, 8'hFE);
    prog[254] = enc_i(4'h6, 3'd7, 8'h01);
    prog[255] = 16'h0000;
    prog[1]   = enc_i(4'h8, 3'd0, 8'h40);
    prog[64]  = enc_r(4'h3, 3'd1, 3'd7, 3'd7);
    run_prog("wrap");
    chk("wrap_r1", rf[1], 8'h01);

    // illegal opcode then HALT
    clear_prog();
    prog[0] = 16'hC000;
    prog[1] = enc_r(4'h4, 3'd2, 3'd0, 3'd1);
    run_prog("illegal");

    // random forward-only programs with random wait states
    fixed_wait = -1;
    wait_max = 3;
    for (int p = 0; p < 8; p++) begin
      clear_prog();
      for (int i = 0; i < 8; i++) rf_init[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      for (int a = 0; a < 30; a++) begin
        case ($urandom_range(0, 9))
          0: prog[a] = 16'h0000;
          4: prog[a] = enc_i(4'h6, 3'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
          5: prog[a] = enc_r(4'h7, 3'($urandom), 3'($urandom), 3'($urandom));
          6: prog[a] = enc_i(4'h8, 3'($urandom), 8'($urandom_range(a + 1, 30)));
          7: prog[a] = enc_i(4'h9, 3'($urandom), 8'($urandom_range(a + 1, 30)));
          8: prog[a] = {4'($urandom_range(10, 14)), 12'($urandom)};
          default: prog[a] = enc_r(4'($urandom_range(1, 5)), 3'($urandom), 3'($urandom), 3'($urandom));
        endcase
      end
      run_prog("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
